serial_nibble_adder: RTL and testbench

Multi-precision adder that builds a 4·NIBBLES-bit sum from a stream of 4-bit operand nibble pairs, least-significant nibble first. One 4-bit ripple adder is reused across cycles, with carry registered between nibbles. It accepts nibbles over a valid/ready handshake, assembles the result in a shift/position register, and presents the full word with carry-out and signed overflow over a second valid/ready handshake to the downstream consumer.

---
 rtl/sna_pkg.sv | 21 ++
 rtl/serial_nibble_adder_if.sv | 30 +++
 rtl/four_bit_adder.sv | 12 +
 rtl/serial_nibble_adder.sv | 122 ++++++++++++
 tb/tb_serial_nibble_adder.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/sna_pkg.sv
// Shared types and constants for the serial nibble adder.
package sna_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Ceiling log2, used to size the nibble index (callers guarantee n >= 2).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_nibble_adder_if.sv
// Nibble input and word result handshakes of the serial nibble adder.
interface serial_nibble_adder_if
    import sna_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = NIB_W * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [NIB_W-1:0] in_a;
    logic [NIB_W-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/four_bit_adder.sv
// Shared 4-bit adder stage reused for every nibble of a word.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-precision adder: one nibble pair per accepted beat, LSB first, word result held until taken.
// Optional signed overflow output enabled by defining SERIAL_NIBBLE_ADDER_OVF_EN.
module serial_nibble_adder
    import sna_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_nibble_adder_if.slave bus
);

    localparam int unsigned W     = NIB_W * NIBBLES;
    localparam int unsigned IDX_W = clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [NIB_W-1:0] add_s;
    logic             add_cin;
    logic             add_cy;

    four_bit_adder u_adder (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .cin  (add_cin),
        .sum  (add_s),
        .cout (add_cy)
    );

    assign add_cin = (idx_q == '0) ? bus.in_cin : carry_q;

`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    logic ovf_nib;

    // Signed overflow: like-signed operands producing an opposite-signed top nibble.
    assign ovf_nib = (bus.in_a[NIB_W-1] == bus.in_b[NIB_W-1]) &&
                     (add_s[NIB_W-1] != bus.in_a[NIB_W-1]);
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    for (int unsigned i = 0; i < NIBBLES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_d[i*NIB_W +: NIB_W] = add_s;
                        end
                    end
                    carry_d = add_cy;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        cout_d  = add_cy;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
                        ovf_d   = ovf_nib;
`endif
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_ovf = ovf_q;
`else
    assign bus.out_ovf = 1'b0;
`endif

    // in_ready depends on state and reset only, never on out_ready.
    assign bus.in_ready  = (state_q == ACCUM) && !rst;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed self-checking bench for serial_nibble_adder with NIBBLES=4.
module tb_serial_nibble_adder;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    serial_nibble_adder_if #(.NIBBLES(4)) bus ();

    serial_nibble_adder #(.NIBBLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    localparam logic OVF_7FFF = 1'b1;
`else
    localparam logic OVF_7FFF = 1'b0;
`endif

    // Drive nnib nibbles of a word starting at a negedge; returns at the negedge after the last accept.
    task automatic send_word(input logic [15:0] a, input logic [15:0] b, input logic cin,
                             input int gap, input int nnib, output logic pre_valid);
        int n;
        pre_valid = 1'b0;
        for (int i = 0; i < nnib; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = a[4*i +: 4];
            bus.in_b     = b[4*i +: 4];
            bus.in_cin   = (i == 0) ? cin : ~cin;
            n = 0;
            while (!bus.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!bus.in_ready) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
            end
            pre_valid = bus.out_valid;
            @(posedge clk);
            @(negedge clk);
            if (gap > 0 && i < nnib - 1) begin
                bus.in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 4'h0;
        bus.in_b      = 4'h0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h0000) begin errors++; $display("FAIL reset_out_sum: got %h want 0000", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %0b want 0", bus.out_cout); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %0b want 0", bus.out_ovf); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        logic pv;
        bus.out_ready = 1'b1;
        send_word(16'h1234, 16'h1111, 1'b0, 0, 4, pv);
        checks++; if (pv !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b want 0", pv); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%0b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h2345) begin errors++; $display("FAIL basic_sum: got %h want 2345", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %0b want 0", bus.out_cout); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b want 0", bus.out_ovf); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready: got %0b want 0", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_drain_ready: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_carry_out();
        logic pv;
        send_word(16'hFFFF, 16'h0001, 1'b0, 0, 4, pv);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL carry_valid: got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h0000) begin errors++; $display("FAIL carry_sum: got %h want 0000", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b1) begin errors++; $display("FAIL carry_cout: got %0b want 1", bus.out_cout); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL carry_ovf: got %0b want 0", bus.out_ovf); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic pv;
        send_word(16'h7FFF, 16'h0001, 1'b0, 0, 4, pv);
        checks++; if (bus.out_sum !== 16'h8000) begin errors++; $display("FAIL ovf_sum: got %h want 8000", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL ovf_cout: got %0b want 0", bus.out_cout); end
        checks++; if (bus.out_ovf !== OVF_7FFF) begin errors++; $display("FAIL ovf_flag: got %0b want %0b", bus.out_ovf, OVF_7FFF); end
        @(negedge clk);
    endtask

    task automatic test_gaps();
        logic pv;
        send_word(16'h0000, 16'h0000, 1'b1, 3, 4, pv);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h0001) begin errors++; $display("FAIL gap_sum: got %h want 0001", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL gap_cout: got %0b want 0", bus.out_cout); end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic pv;
        bus.out_ready = 1'b0;
        send_word(16'h1234, 16'h1111, 1'b0, 0, 4, pv);
        // Offer a nibble of the next word while the result is stalled.
        bus.in_valid = 1'b1;
        bus.in_a     = 4'h2;
        bus.in_b     = 4'h4;
        bus.in_cin   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b want 0", c, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", c, bus.out_valid); end
            checks++; if (bus.out_sum !== 16'h2345) begin errors++; $display("FAIL bp_sum[%0d]: got %h want 2345", c, bus.out_sum); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", bus.in_ready); end
        send_word(16'h0102, 16'h0304, 1'b0, 0, 4, pv);
        checks++; if (bus.out_sum !== 16'h0406) begin errors++; $display("FAIL bp_next_sum: got %h want 0406", bus.out_sum); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_word();
        logic pv;
        bus.out_ready = 1'b1;
        send_word(16'h00FF, 16'h0001, 1'b0, 0, 2, pv);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %0b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h0000) begin errors++; $display("FAIL mid_rst_sum: got %h want 0000", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL mid_rst_cout: got %0b want 0", bus.out_cout); end
        rst = 1'b0;
        @(negedge clk);
        send_word(16'h0003, 16'h0004, 1'b0, 0, 4, pv);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_next_valid: got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h0007) begin errors++; $display("FAIL mid_next_sum: got %h want 0007", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL mid_next_cout: got %0b want 0", bus.out_cout); end
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry_out();
        test_overflow();
        test_gaps();
        test_back_pressure();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
